// File: rtl/clut_lookup.sv
// clut_lookup: two-stage colour-index to RGB lookup with transparency key, flush and back-pressure
module clut_lookup #(
  parameter int DEPTH   = 256,
  parameter int COLOR_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               src_write,
  input  logic [7:0]         src_pixel,
  output logic               src_strobe,
  output logic               dst_write,
  output logic [COLOR_W-1:0] dst_rgb,
  output logic               dst_transparent,
  input  logic               dst_strobe,
  input  logic               clut7,
  input  logic               bank,
  input  logic               trans_en,
  input  logic [7:0]         trans_key,
  input  logic               flush,
  input  logic               clut_we,
  input  logic [7:0]         clut_addr,
  input  logic [COLOR_W-1:0] clut_data
);
  logic [COLOR_W-1:0] mem [DEPTH];
  logic [COLOR_W-1:0] ram_q, rgb_q, rgb_d;
  logic               v1_q, v1_d, v2_q, v2_d, t1_q, t1_d, t2_q, t2_d;
  logic               advance, trans_hit;
  logic [7:0]         rd_addr;

  assign advance    = (!v2_q || dst_strobe) && !flush;
  assign src_strobe = advance && reset_n;
  assign rd_addr    = clut7 ? {bank, src_pixel[6:0]} : src_pixel;
  assign trans_hit  = trans_en && (src_pixel == trans_key);

  // Read-first: a same-cycle write to the read address is seen one cycle later
  always_ff @(posedge clk) begin
    if (clut_we) mem[clut_addr] <= clut_data;
    if (advance) ram_q <= mem[rd_addr];
  end

  always_comb begin
    v1_d  = flush ? 1'b0 : (advance ? src_write : v1_q);
    v2_d  = flush ? 1'b0 : (advance ? v1_q : v2_q);
    t1_d  = advance ? trans_hit : t1_q;
    t2_d  = advance ? t1_q : t2_q;
    rgb_d = advance ? ram_q : rgb_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      t1_q  <= 1'b0;
      t2_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      t1_q  <= t1_d;
      t2_q  <= t2_d;
      rgb_q <= rgb_d;
    end
  end

  assign dst_write       = v2_q;
  assign dst_rgb         = rgb_q;
  assign dst_transparent = t2_q;
endmodule

// File: tb/tb_clut_lookup.sv
// tb_clut_lookup: directed self-checking bench for clut_lookup
module tb_clut_lookup;
  logic        clk = 0, reset_n = 0;
  logic        src_write = 0, dst_strobe = 1, clut7 = 0, bank = 0, trans_en = 0, flush = 0, clut_we = 0;
  logic [7:0]  src_pixel = 0, trans_key = 0, clut_addr = 0;
  logic [23:0] clut_data = 0;
  logic        src_strobe, dst_write, dst_transparent;
  logic [23:0] dst_rgb;
  int n_cmp = 0, n_bad = 0;

  clut_lookup dut (
    .clk(clk), .reset_n(reset_n), .src_write(src_write), .src_pixel(src_pixel),
    .src_strobe(src_strobe), .dst_write(dst_write), .dst_rgb(dst_rgb),
    .dst_transparent(dst_transparent), .dst_strobe(dst_strobe), .clut7(clut7),
    .bank(bank), .trans_en(trans_en), .trans_key(trans_key), .flush(flush),
    .clut_we(clut_we), .clut_addr(clut_addr), .clut_data(clut_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    clut_we = 1; clut_addr = a; clut_data = d;
    step();
    clut_we = 0;
  endtask

  initial begin
    step(); step();
    chk("rst_write", dst_write, 0);
    chk("rst_strobe", src_strobe, 0);
    chk("rst_rgb", dst_rgb, 0);
    chk("rst_trans", dst_transparent, 0);
    #2 reset_n = 1;
    step();
    wr(8'h05, 24'h123456);
    wr(8'h85, 24'hABCDEF);
    wr(8'h00, 24'h0000AA);

    // 1: back-to-back lookups
    src_write = 1; src_pixel = 8'h05; #1;
    chk("t1_strobe", src_strobe, 1);
    step();
    src_pixel = 8'h85;
    step();
    src_write = 0;
    chk("t1_v0", dst_write, 1);
    chk("t1_rgb0", dst_rgb, 24'h123456);
    step();
    chk("t1_v1", dst_write, 1);
    chk("t1_rgb1", dst_rgb, 24'hABCDEF);
    step();
    chk("t1_drain", dst_write, 0);

    // 2: downstream stall
    dst_strobe = 0;
    src_write = 1; src_pixel = 8'h05;
    step();
    src_pixel = 8'h85;
    step();
    src_write = 0; #1;
    chk("t2_full_strobe", src_strobe, 0);
    step(); step();
    chk("t2_hold_v", dst_write, 1);
    chk("t2_hold_rgb", dst_rgb, 24'h123456);
    chk("t2_hold_strobe", src_strobe, 0);
    dst_strobe = 1; #1;
    chk("t2_release_strobe", src_strobe, 1);
    step();
    chk("t2_next_v", dst_write, 1);
    chk("t2_next_rgb", dst_rgb, 24'hABCDEF);
    step();
    chk("t2_once", dst_write, 0);

    // 3: 7-bit mode with bank, bank changed between pixels
    clut7 = 1; bank = 1; src_write = 1; src_pixel = 8'h05;
    step();
    bank = 0; src_pixel = 8'h85;
    step();
    src_write = 0;
    chk("t3_bank1", dst_rgb, 24'hABCDEF);
    step();
    chk("t3_bank0", dst_rgb, 24'h123456);
    chk("t3_v", dst_write, 1);
    clut7 = 0;
    step();

    // 4: transparency key
    trans_en = 1; trans_key = 8'h00; src_write = 1; src_pixel = 8'h00;
    step();
    src_pixel = 8'h05;
    step();
    trans_en = 0; src_pixel = 8'h00;
    chk("t4_hit", dst_transparent, 1);
    chk("t4_hit_rgb", dst_rgb, 24'h0000AA);
    step();
    src_write = 0;
    chk("t4_miss", dst_transparent, 0);
    chk("t4_miss_rgb", dst_rgb, 24'h123456);
    step();
    chk("t4_dis", dst_transparent, 0);
    chk("t4_dis_rgb", dst_rgb, 24'h0000AA);
    step();

    // 5: flush with two pixels in flight
    src_write = 1; src_pixel = 8'h05;
    step();
    src_pixel = 8'h85;
    step();
    flush = 1; #1;
    chk("t5_flush_strobe", src_strobe, 0);
    step();
    flush = 0; src_write = 0;
    chk("t5_drop0", dst_write, 0);
    step();
    chk("t5_drop1", dst_write, 0);
    step();
    chk("t5_drop2", dst_write, 0);
    src_write = 1; src_pixel = 8'h85;
    step();
    src_write = 0;
    chk("t5_lat1", dst_write, 0);
    step();
    chk("t5_lat2", dst_write, 1);
    chk("t5_rgb", dst_rgb, 24'hABCDEF);
    step();

    // 6: async reset mid-stream, then read-first write collision
    src_write = 1; src_pixel = 8'h05;
    step(); step();
    chk("t6_pre", dst_write, 1);
    #2 reset_n = 0;
    #1;
    chk("t6_rst_v", dst_write, 0);
    chk("t6_rst_strobe", src_strobe, 0);
    chk("t6_rst_rgb", dst_rgb, 0);
    src_write = 0;
    step();
    #3 reset_n = 1;
    step();
    src_write = 1; src_pixel = 8'h85;
    step();
    src_write = 0;
    step();
    chk("t6_retain", dst_rgb, 24'hABCDEF);
    src_write = 1; src_pixel = 8'h05; clut_we = 1; clut_addr = 8'h05; clut_data = 24'h000001;
    step();
    clut_we = 0;
    step();
    src_write = 0;
    chk("t6_old", dst_rgb, 24'h123456);
    step();
    chk("t6_new", dst_rgb, 24'h000001);
    chk("t6_v", dst_write, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clut_lookup.md
Name: clut_lookup

Overview:
- Colour lookup stage directly downstream of the CLUT7/CLUT8 RLE decompressor.
- Consumes the decoded 8-bit colour-index pixel stream and translates each index through a 256-entry x 24-bit CLUT RAM, which the CPU/register interface loads.
- Emits a 24-bit RGB pixel stream with a per-pixel transparency flag to the plane mixer.
- Fully pipelined: 1 pixel/clock, back-pressure honoured end to end.

Parameters:
- DEPTH, 256, number of CLUT entries; the address width is log2(DEPTH) = 8.
- COLOR_W, 24, bits per CLUT entry, {R[23:16], G[15:8], B[7:0]}.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- src_write  in  1  upstream pixel valid.
- src_pixel  in  8  colour index from the RLE stage.
- src_strobe  out  1  accept; a transfer occurs when src_write && src_strobe.
- dst_write  out  1  output pixel valid.
- dst_rgb  out  COLOR_W  looked-up colour.
- dst_transparent  out  1  transparency flag aligned with dst_rgb.
- dst_strobe  in  1  downstream accept; a transfer occurs when dst_write && dst_strobe.
- clut7  in  1  1 = 7-bit index mode, 0 = 8-bit index mode.
- bank  in  1  CLUT bank for clut7 mode.
- trans_en  in  1  enable transparency-key compare.
- trans_key  in  8  raw index treated as transparent.
- flush  in  1  synchronous pipeline flush, asserted at line/frame start.
- clut_we  in  1  CLUT write enable.
- clut_addr  in  8  CLUT write address.
- clut_data  in  COLOR_W  CLUT write data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - v1, v2, dst_write, dst_transparent = 0; dst_rgb = 0.
  - CLUT RAM contents are not reset.
  - src_strobe = 0 while reset_n is low.
- Pipeline: S1 = synchronous RAM read register; S2 = output register. Valid bits v1 and v2.
- advance = (!v2 || dst_strobe) && !flush.
- src_strobe = advance. It is combinational and may depend on dst_strobe in the same cycle.
- Read address:
  - clut7 = 1: {bank, src_pixel[6:0]}.
  - clut7 = 0: src_pixel[7:0].
  - clut7 and bank are sampled at the accept cycle only.
- Transparency: trans_hit = trans_en && (src_pixel == trans_key), compared on the raw 8-bit index. trans_hit is computed at accept and carried alongside v1.
- On advance:
  - RAM read enable = 1; v1 <= src_write.
  - v2 <= v1; dst_rgb <= ram_q; dst_transparent <= S1 flag.
- On !advance: RAM read enable = 0. ram_q, v1, v2 and all S2 registers hold. A stalled pixel is never lost or duplicated.
- dst_write = v2.
- Latency: a pixel accepted in cycle N appears on dst_write/dst_rgb in cycle N+2 if there is no stall. Throughput is 1 pixel/clock.
- A bubble (src_write = 0 at advance) propagates as v1 = 0. dst_rgb keeps its last value when v2 = 0 and is don't-care.
- Flush:
  - In the cycle flush is high, src_strobe = 0.
  - At the next edge v1 <= 0 and v2 <= 0, regardless of dst_strobe.
  - Pixels in flight are dropped.
- CLUT write port:
  - Independent of stream state; it is never blocked.
  - A write in cycle N is visible to reads issued in cycle N+1 or later.
  - A same-address read and write in the same cycle returns the OLD value (read-first).
- Mode change (clut7/bank) mid-stream affects only pixels accepted afterwards.
- Width rules: index compare is 8-bit unsigned; no arithmetic.
- No other state; no FSM beyond the v1/v2 occupancy (states EMPTY, S1, S2, FULL = {v1, v2}).

Test Plan:
1. Load CLUT[0x05] = 0x123456 and CLUT[0x85] = 0xABCDEF. Set clut7 = 0, dst_strobe = 1. Stream 0x05 then 0x85 in cycles 10 and 11 -> dst_write high in cycles 12 and 13 with 0x123456 then 0xABCDEF.
2. Same stream with dst_strobe held 0 for cycles 12–15 -> src_strobe = 0 once v1 and v2 are full. dst_rgb holds 0x123456. After release, 0x123456 and 0xABCDEF are each delivered exactly once.
3. Set clut7 = 1, bank = 1, index 0x05 -> output 0xABCDEF. With bank = 0 and index 0x85 -> output 0x123456.
4. Set trans_en = 1, trans_key = 0x00, stream 0x00, 0x05 -> dst_transparent = 1 then 0, aligned with the RGB values. With trans_en = 0 the flag stays 0.
5. With 2 pixels in flight, pulse flush for 1 cycle -> no dst_write in the following cycles; the next accepted pixel emerges 2 cycles after acceptance.
6. Pull reset_n low mid-stream (asynchronous, off-edge) -> dst_write and src_strobe drop immediately and dst_rgb = 0. After release, CLUT contents are retained and a new lookup returns the stored values. Same-cycle write/read of 0x05 with new data 0x000001 -> that read returns 0x123456; the next read returns 0x000001.
